// File: rtl/exec_div_ctrl_pkg.sv
// Shared constants for the Execute-stage divide sequencer: M-extension encodings and FSM states.
package exec_div_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // True for the four divide/remainder encodings of the OP opcode.
  function automatic logic is_div_op(input logic [6:0] funct7, input logic [2:0] funct3);
    return (funct7 == FUNCT7_MULDIV) && funct3[2];
  endfunction

  function automatic logic op_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] funct3);
    return (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);
  endfunction

  function automatic logic [XLEN-1:0] cond_negate(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/exec_div_ctrl_div_step.sv
// One combinational restoring-division iteration on {rem, quo}.
module exec_div_ctrl_div_step
  import exec_div_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor always holds, so the shifted value fits 33 bits and diff[32] is the borrow.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  assign quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
  assign rem_o = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

endmodule

// File: rtl/exec_div_ctrl.sv
// Execute-stage divide sequencer: stalls the pipeline for a 32-step restoring divide and
// returns a registered quotient/remainder with a one-cycle done pulse.
module exec_div_ctrl
  import exec_div_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  logic [1:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            sel_rem_q, sel_rem_d;

  logic            req_signed;
  logic            req_rem;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;
  logic [XLEN-1:0] final_quo;
  logic [XLEN-1:0] final_rem;
  logic [XLEN-1:0] final_res;

  // Request decode, evaluated only while IDLE.
  assign req_signed = op_is_signed(funct3_i);
  assign req_rem    = op_is_rem(funct3_i);
  assign a_neg      = req_signed & rs1_val_i[XLEN-1];
  assign b_neg      = req_signed & rs2_val_i[XLEN-1];
  assign div_zero   = (rs2_val_i == '0);
  assign overflow   = req_signed && (rs1_val_i == 32'h8000_0000) && (rs2_val_i == 32'hFFFF_FFFF);

  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = req_rem ? rs1_val_i : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_res = req_rem ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  exec_div_ctrl_div_step u_div_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign final_quo = cond_negate(step_quo, neg_quo_q);
  assign final_rem = cond_negate(step_rem, neg_rem_q);
  assign final_res = sel_rem_q ? final_rem : final_quo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;

    case (state_q)
      DIV_IDLE: begin
        if (start_i && !flush_i) begin
          if (div_zero || overflow) begin
            result_d = special_res;
            state_d  = DIV_DONE;
          end else begin
            rem_d     = '0;
            quo_d     = cond_negate(rs1_val_i, a_neg);
            dvsr_d    = cond_negate(rs2_val_i, b_neg);
            cnt_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            sel_rem_d = req_rem;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = final_res;
          state_d  = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    // A killed instruction must never publish a result.
    if (flush_i) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

  assign stall_o  = start_i && (state_q != DIV_DONE) && !flush_i && !rst_i;
  assign done_o   = (state_q == DIV_DONE);
  assign busy_o   = (state_q == DIV_BUSY);
  assign result_o = result_q;

endmodule

// File: tb/tb_exec_div_ctrl.sv
// Self-checking bench for exec_div_ctrl against an arithmetic reference model.
module tb_exec_div_ctrl;
  import exec_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic        busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_result;

  always #5 clk = ~clk;

  exec_div_ctrl dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .funct3_i  (funct3),
    .rs1_val_i (rs1_val),
    .rs2_val_i (rs2_val),
    .flush_i   (flush),
    .stall_o   (stall),
    .done_o    (done),
    .result_o  (result),
    .busy_o    (busy)
  );

  // RISC-V M-extension semantics computed with plain arithmetic.
  task automatic ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output int lat);
    logic [31:0] q;
    logic [31:0] rm;
    bit          sgn;
    bit          is_rem;
    sgn    = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
    is_rem = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; rm = a; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; rm = 32'd0; lat = 1;
    end else begin
      lat = 33;
      if (sgn) begin
        q  = $signed(a) / $signed(b);
        rm = $signed(a) % $signed(b);
      end else begin
        q  = a / b;
        rm = a % b;
      end
    end
    r = is_rem ? rm : q;
  endtask

  // Issues one request and follows it to its done pulse, checking stall/busy/latency/result.
  task automatic do_op(input bit wait_first, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input string tag, output logic [31:0] got);
    logic [31:0] exp_r;
    int          lat;
    int          cyc;
    int          stalls;
    int          busys;
    bit          seen;
    ref_model(f3, a, b, exp_r, lat);
    if (wait_first) @(negedge clk);
    start = 1'b1; funct3 = f3; rs1_val = a; rs2_val = b; flush = 1'b0;
    cyc = 0; stalls = 0; busys = 0; seen = 0; got = 'x;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL %s stall_at_issue: got %b want 1", tag, stall);
    end
    while (!seen && cyc < 100) begin
      if (done === 1'b1) begin
        seen = 1;
        got  = result;
        n_checks++;
        if (result !== exp_r) begin
          n_fail++; $display("FAIL %s result: got %h want %h", tag, result, exp_r);
        end
        n_checks++;
        if (cyc != lat) begin
          n_fail++; $display("FAIL %s done_cycle: got %0d want %0d", tag, cyc, lat);
        end
        n_checks++;
        if (stalls != lat) begin
          n_fail++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, lat);
        end
        n_checks++;
        if (busys != lat - 1) begin
          n_fail++; $display("FAIL %s busy_cycles: got %0d want %0d", tag, busys, lat - 1);
        end
        n_checks++;
        if (stall !== 1'b0) begin
          n_fail++; $display("FAIL %s stall_in_done: got %b want 0", tag, stall);
        end
        start = 1'b0;
        last_result = exp_r;
      end else begin
        if (stall === 1'b1) stalls++;
        if (busy === 1'b1) busys++;
        @(negedge clk);
        cyc++;
        #1;
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles, want %0d", tag, cyc, lat);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; funct3 = FUNCT3_DIVU; rs1_val = 32'd100; rs2_val = 32'd7;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h want 0 0 0 0",
               busy, done, stall, result);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    last_result = 32'd0;
  endtask

  task automatic check_hold(input string tag);
    @(negedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || result !== last_result) begin
      n_fail++;
      $display("FAIL %s hold: done=%b result=%h want 0 %h", tag, done, result, last_result);
    end
  endtask

  task automatic test_directed();
    logic [31:0] got;
    logic [31:0] want [9];
    logic [2:0]  f3s  [9];
    logic [31:0] as   [9];
    logic [31:0] bs   [9];
    f3s = '{FUNCT3_DIVU, FUNCT3_REMU, FUNCT3_DIV, FUNCT3_REM, FUNCT3_REM,
            FUNCT3_DIV, FUNCT3_REMU, FUNCT3_DIV, FUNCT3_REM};
    as  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    want = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 9; i++) begin
      do_op(1'b1, f3s[i], as[i], bs[i], $sformatf("directed%0d", i), got);
      n_checks++;
      if (got !== want[i]) begin
        n_fail++; $display("FAIL directed%0d value: got %h want %h", i, got, want[i]);
      end
      check_hold($sformatf("directed%0d", i));
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      do_op(1'b1, f3, a, b, $sformatf("rand%0d", i), got);
    end
  endtask

  task automatic test_flush();
    logic [31:0] got;
    do_op(1'b1, FUNCT3_DIVU, 32'd1000, 32'd10, "flush_pre", got);
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; rs1_val = 32'd77; rs2_val = 32'd5;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle: stall=%b busy=%b want 0 1", stall, busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd100) begin
      n_fail++;
      $display("FAIL flush_after: busy=%b done=%b result=%h want 0 0 00000064",
               busy, done, result);
    end
    // Restart in the same IDLE cycle that follows the flush.
    do_op(1'b0, FUNCT3_DIVU, 32'd77, 32'd5, "flush_restart", got);
    n_checks++;
    if (got !== 32'd15) begin
      n_fail++; $display("FAIL flush_restart value: got %h want 0000000f", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got;
    do_op(1'b1, FUNCT3_DIVU, 32'd1000, 32'd10, "b2b_first", got);
    n_checks++;
    if (got !== 32'd100) begin
      n_fail++; $display("FAIL b2b_first value: got %h want 00000064", got);
    end
    do_op(1'b1, FUNCT3_REMU, 32'd1000, 32'd7, "b2b_second", got);
    n_checks++;
    if (got !== 32'd6) begin
      n_fail++; $display("FAIL b2b_second value: got %h want 00000006", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    @(negedge clk);
    start = 1'b1; funct3 = FUNCT3_DIVU; rs1_val = 32'd12345; rs2_val = 32'd67;
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b stall=%b result=%h want 0 0 0 0",
               busy, done, stall, result);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    last_result = 32'd0;
    do_op(1'b1, FUNCT3_DIVU, 32'd9, 32'd3, "reset_mid_next", got);
    n_checks++;
    if (got !== 32'd3) begin
      n_fail++; $display("FAIL reset_mid_next value: got %h want 00000003", got);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
